// File: rtl/deco_hold_multicanal.sv
// Port-write hold decoder: maps PicoBlaze port writes onto N_CH active-low hold pulses
// with a one-deep pending slot, per-channel enable, sticky error flags and a release ack.
module deco_hold_multicanal #(
  parameter int         N_CH      = 9,
  parameter logic [7:0] BASE_ADDR = 8'h03,
  parameter int         SKIP_EN   = 1,
  parameter logic [7:0] SKIP_ADDR = 8'h09,
  parameter int         PULSE_LEN = 2,
  parameter int         GAP_LEN   = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            write_strobe,
  input  logic [7:0]      port_id,
  input  logic [N_CH-1:0] en_mask,
  input  logic            clr_err,
  output logic [N_CH-1:0] hold_n,
  output logic            busy,
  output logic [3:0]      ch_act,
  output logic            ack,
  output logic            err_addr,
  output logic            err_ovf
);

  // state | meaning
  // IDLE  | no pulse in flight; a valid write or a pending entry starts one
  // PULSE | one hold line low, counter runs down the pulse length
  // GAP   | all holds high, counter runs down the recovery gap
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_LD   = (GAP_LEN == 0) ? 4'd0 : 4'(GAP_LEN - 1);
  localparam bit         NO_GAP   = (GAP_LEN == 0);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       pend_vld, pend_vld_nx;
  logic [3:0] pend_ch;

  logic       hit, hit_en;
  logic [3:0] dec_ch;
  logic       wr_valid, direct, at_dec, start, consume;
  logic       wr_to_pend, ovf_evt, addr_evt;
  logic [3:0] start_ch;

  function automatic logic [7:0] map_addr(input int i);
    int a;
    a = int'(BASE_ADDR) + i;
    if (SKIP_EN != 0 && a >= int'(SKIP_ADDR)) a = a + 1;
    return a[7:0];
  endfunction

  always_comb begin
    hit    = 1'b0;
    hit_en = 1'b0;
    dec_ch = 4'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (port_id == map_addr(i)) begin
        hit    = 1'b1;
        hit_en = en_mask[i];
        dec_ch = 4'(i);
      end
    end
  end

  always_comb begin
    wr_valid = write_strobe && hit && hit_en;
    addr_evt = write_strobe && !hit;
    direct   = (state == IDLE) && !pend_vld && wr_valid;
    // Decision points: where the next pulse may start from pending (or a fresh write in IDLE)
    at_dec   = (state == IDLE) ||
               (state == GAP && cnt == 4'd0) ||
               (state == PULSE && cnt == 4'd0 && NO_GAP);
    consume  = at_dec && pend_vld;
    start    = at_dec && (pend_vld || direct);
    start_ch = pend_vld ? pend_ch : dec_ch;
    // A slot consumed on this edge counts as free for an arriving write
    wr_to_pend  = wr_valid && !direct && (!pend_vld || consume);
    ovf_evt     = wr_valid && !direct && pend_vld && !consume;
    pend_vld_nx = wr_to_pend ? 1'b1 : (consume ? 1'b0 : pend_vld);

    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? PULSE : IDLE;
      PULSE:   if (cnt == 4'd0) begin
                 if (NO_GAP) state_nx = start ? PULSE : IDLE;
                 else        state_nx = GAP;
               end
      GAP:     if (cnt == 4'd0) state_nx = start ? PULSE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      pend_vld <= 1'b0;
      pend_ch  <= 4'd0;
      hold_n   <= '1;
      busy     <= 1'b0;
      ch_act   <= 4'd0;
      ack      <= 1'b0;
      err_addr <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      state    <= state_nx;
      pend_vld <= pend_vld_nx;
      if (wr_to_pend) pend_ch <= dec_ch;
      busy     <= (state_nx != IDLE) || pend_vld_nx;
      ack      <= (state == PULSE) && (cnt == 4'd0);
      if (start) begin
        hold_n <= ~(N_CH'(1) << start_ch);
        ch_act <= start_ch;
        cnt    <= PULSE_LD;
      end else if (state == PULSE && cnt == 4'd0) begin
        hold_n <= '1;
        cnt    <= GAP_LD;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      err_addr <= addr_evt || (err_addr && !clr_err);
      err_ovf  <= ovf_evt  || (err_ovf  && !clr_err);
    end
  end

endmodule

// File: doc/deco_hold_multicanal.md
Name: deco_hold_multicanal

Overview:
- Parametrised, clocked successor of the PicoBlaze port-write hold decoder.
- Decodes `port_id` on `write_strobe` into one of N_CH active-low hold lines for the RTC time/date/timer registers.
- Each hold is a registered pulse of programmable length, followed by a recovery gap.
- Adds a one-deep pending queue, a per-channel enable mask, sticky error flags and a completion acknowledge.
- Sits between the PicoBlaze output port and the RTC register bank.

Parameters:
- N_CH, 9, number of hold channels (1..16).
- BASE_ADDR, 8'h03, port_id of channel 0.
- SKIP_EN, 1, when 1 the address SKIP_ADDR is unmapped and later channels shift up by one.
- SKIP_ADDR, 8'h09, unmapped address inside the range; must satisfy BASE_ADDR < SKIP_ADDR < BASE_ADDR+N_CH.
- PULSE_LEN, 2, cycles each hold line stays low (1..15).
- GAP_LEN, 1, idle cycles after a pulse before the next may start (0..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- write_strobe  in  1  PicoBlaze write strobe; one cycle per write.
- port_id  in  8  PicoBlaze port address.
- en_mask  in  N_CH  per-channel enable; 0 = writes to that channel ignored.
- clr_err  in  1  synchronous clear of err_addr and err_ovf.
- hold_n  out  N_CH  registered active-low hold lines, at most one low at a time.
- busy  out  1  high in PULSE or GAP, or while pending is valid.
- ch_act  out  4  index of the channel currently or last pulsed.
- ack  out  1  one-cycle pulse on the cycle the hold line returns high.
- err_addr  out  1  sticky: strobe seen with an unmapped address.
- err_ovf  out  1  sticky: valid write dropped because the queue was full.

Behaviour:
- Reset is asynchronous, active-low and takes effect mid-operation too. Reset values:
  - hold_n all 1s; busy 0; ch_act 0; ack 0; err_addr 0; err_ovf 0.
  - FSM in IDLE; pending invalid; counter 0.
- Address map:
  - Channel i maps to BASE_ADDR+i, plus 1 when SKIP_EN=1 and BASE_ADDR+i >= SKIP_ADDR.
  - Any other port_id is unmapped.
  - Decode is combinational on the strobe cycle; all outputs are registered.
- A write is valid when write_strobe=1, the address is mapped and en_mask[ch]=1.
  - Mapped but masked: ignored, no error.
  - Unmapped: sets err_addr, no hold.
- FSM states: IDLE, PULSE, GAP.
  - IDLE + valid write at edge k: enter PULSE, load ch_act, hold_n[ch]=0 from edge k (visible cycle k+1), counter=PULSE_LEN-1. Latency is one clock.
  - PULSE: counter decrements each cycle. At 0, hold_n returns all 1s and ack=1 for that one cycle. Then enter GAP (counter=GAP_LEN-1) or, if GAP_LEN=0, go directly to the pending/IDLE decision.
  - GAP: all holds high. When the counter reaches 0:
    - if pending is valid, enter PULSE with the pending channel and clear pending;
    - otherwise enter IDLE.
  - The hold line stays low for exactly PULSE_LEN cycles.
  - Between consecutive pulses there are exactly GAP_LEN high cycles; with GAP_LEN=0 pulses are back-to-back, with the same edge releasing one line and asserting the next.
- Queueing:
  - A valid write while not IDLE is stored in the one-deep pending register, if pending is empty.
  - If pending is full, the write is dropped and err_ovf is set.
  - A write arriving on the same edge that pending is consumed is accepted into pending; the slot is treated as freed first.
- The pending channel's en_mask is checked at acceptance only.
- Sticky flags:
  - clr_err has lower priority than a simultaneous setting event: the flag stays 1.
  - A flag is cleared only when clr_err=1 and no setting event occurs that cycle.
- write_strobe held high for several cycles counts as one write per cycle.
- ch_act is 4 bits; unused upper bits are 0 when N_CH < 16.

Test Plan:
1. Defaults. Reset, then strobe port_id=8'h05 → hold_n = 9'b1_1111_1011 for 2 cycles starting 1 cycle after the strobe; ack pulses on release; ch_act=2; busy drops after the 1 GAP cycle.
2. Skip mapping. Strobe 8'h0A → channel 6 low. Strobe 8'h09 → err_addr=1, no hold. Strobe 8'h0D → err_addr=1. clr_err → err_addr=0.
3. Queue and overflow. Strobes to 8'h03, 8'h04 and 8'h06 on consecutive cycles:
   - channel 0 pulses, 1 GAP cycle, then channel 1 pulses;
   - 8'h06 is dropped and err_ovf=1.
4. Mask. en_mask[3]=0, strobe 8'h06 → no hold, no error, busy stays 0.
5. Reset mid-pulse. Assert reset_n=0 during PULSE of channel 7 → hold_n returns to all 1s immediately (asynchronous), pending cleared, no ack.
6. Non-default parameters. N_CH=4, BASE_ADDR=8'h20, SKIP_EN=0, PULSE_LEN=3, GAP_LEN=0:
   - back-to-back writes to 8'h21 and 8'h22 → channel 1 low for 3 cycles, channel 2 low immediately after with no gap;
   - ack pulses twice.
